// File: rtl/rv_byte_loader.sv
// rv_byte_loader: upstream program-load stage for the RISC-V top level.
// Synchronises a raw byte strobe, assembles bytes little-endian into 32-bit
// words, buffers them in a 2-entry FIFO and presents each word with a
// sequential word address on a valid/ready write port.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        synchronous active-low reset
//   byte_in      program byte from pins
//   strobe_pin   raw asynchronous byte strobe (one byte per rising edge)
//   clr          synchronous soft clear (does not touch the synchroniser)
//   instr_data   FIFO head word
//   instr_addr   word address of the FIFO head
//   instr_valid  FIFO non-empty
//   instr_ready  downstream accepts the head when high with instr_valid
//   byte_phase   bytes captured into the current partial word
//   overrun      sticky flag: a completed word was dropped
module rv_byte_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              strobe_pin,
  input  logic              clr,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [1:0]        byte_phase,
  output logic              overrun
);

  logic              s1, s2, s3;
  logic              accept;
  logic              word_done;
  logic              pop;
  logic [1:0]        phase;
  logic [23:0]       partial;
  logic [31:0]       full_word;
  logic [31:0]       head, tail;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr;
  logic              ovr;

  // s1 is the metastability catcher; s2/s3 form the rising-edge detector.
  assign accept    = s2 & ~s3;
  assign word_done = accept & (phase == 2'd3);
  // The final byte goes straight into the pushed word on the same edge.
  assign full_word = {byte_in, partial};
  assign pop       = (count != 2'd0) & instr_ready;

  assign instr_data  = head;
  assign instr_addr  = addr;
  assign instr_valid = (count != 2'd0);
  assign byte_phase  = phase;
  assign overrun     = ovr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe_pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      phase   <= '0;
      partial <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      addr    <= '0;
      ovr     <= 1'b0;
    end else begin
      if (accept) begin
        phase <= phase + 2'd1;
        case (phase)
          2'd0:    partial[7:0]   <= byte_in;
          2'd1:    partial[15:8]  <= byte_in;
          2'd2:    partial[23:16] <= byte_in;
          default: ;
        endcase
      end

      if (pop) addr <= addr + 1'b1;

      // head is the FIFO output slot, tail the second entry.
      case ({word_done, pop})
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= full_word;
          end else begin
            head <= full_word;
          end
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head  <= full_word;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            tail  <= full_word;
            count <= 2'd2;
          end else begin
            ovr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv_byte_loader.md
Name: rv_byte_loader

Overview:
- Upstream load stage for the hands-on RISC-V top level.
- Accepts program bytes from the dedicated input pins, qualified by a raw (asynchronous) strobe pin.
- Assembles bytes little-endian into 32-bit instruction words and buffers them in a 2-entry FIFO.
- Presents each word, with a sequential word address, to the core's instruction-memory write port over a valid/ready handshake.

Parameters:
- ADDR_W, 8, width of the word-address counter; wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- byte_in  input  8  program byte from pins; stable from strobe rise until 3 cycles after.
- strobe_pin  input  1  raw asynchronous byte strobe; one byte per rising edge.
- clr  input  1  synchronous soft clear, active-high.
- instr_data  output  32  FIFO head word.
- instr_addr  output  ADDR_W  word address of FIFO head.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  downstream accepts head when high with instr_valid.
- byte_phase  output  2  bytes captured into the current partial word (0..3).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst_n low at an edge):
  - sync flops cleared; byte_phase=0; FIFO empty, so instr_valid=0.
  - address counter=0; overrun=0; instr_data=0 (storage cleared).
- Strobe synchroniser: 3-flop chain s1, s2, s3.
  - accept = s2 & ~s3.
  - A pin rising edge yields exactly one accept pulse, 2 edges after first sampling by s1.
  - Holding the pin high yields no further pulses.
- Byte capture: on an edge with accept=1, byte_in is written to lane byte_phase.
  - Lane 0 = bits 7:0 … lane 3 = bits 31:24.
  - byte_phase increments mod 4.
- Word completion: the accept with byte_phase=3 pushes the assembled word into the FIFO on that same edge.
  - instr_valid is high in the following cycle, if the FIFO was previously empty.
- FIFO: depth 2, in order.
  - Pop on any edge with instr_valid & instr_ready.
  - Push when full is allowed only if a pop occurs on the same edge.
  - Otherwise the word is dropped, overrun is set, and FIFO contents are unchanged.
  - Push and pop on the same edge when empty: impossible, since valid is registered.
- Address: the counter increments on each pop and wraps to 0 after 2^ADDR_W−1.
  - instr_addr always equals the counter.
  - Dropped words consume no address.
- Output stability: instr_data and instr_addr hold while instr_valid=1 and instr_ready=0.
- clr (priority below rst_n, above all else):
  - byte_phase=0 and partial word discarded; FIFO flushed (instr_valid=0 next cycle).
  - address=0; overrun=0.
  - An accept on the same edge as clr is ignored.
  - Sync flops are not cleared.
- Reset mid-word or mid-handshake: everything returns to reset values.
  - No partial word survives.
  - The downstream sees instr_valid fall the cycle after the reset edge.
- overrun clears only via rst_n or clr.

Test Plan:
- Basic assembly:
  - Stimulus: bytes 0x12, 0x34, 0x56, 0x78 via 4 strobe pulses; instr_ready=1.
  - Required: one transfer, instr_data=0x78563412, instr_addr=0; byte_phase reads 1, 2, 3, 0 after each accept.
- Backpressure and overrun:
  - Stimulus: instr_ready=0; send 3 words (0x00000001, 0x00000002, 0x00000003).
  - Required: overrun=1 after the 12th byte. Then instr_ready=1 gives exactly two transfers, 0x00000001 @0 then 0x00000002 @1, with instr_valid=0 afterwards.
- Strobe qualification:
  - Stimulus: strobe_pin held high 20 cycles, then low; then a 1-cycle-wide pulse, offset by half a cycle from clk.
  - Required: exactly two accepts total; byte_phase=2.
- Soft clear mid-word:
  - Stimulus: 2 bytes, clr for 1 cycle, then bytes 0xAA, 0xBB, 0xCC, 0xDD.
  - Required: instr_data=0xDDCCBBAA, instr_addr=0, overrun=0.
- Address wrap (ADDR_W=2):
  - Stimulus: 5 words, instr_ready=1.
  - Required: addresses 0, 1, 2, 3, 0.
- Reset mid-operation:
  - Stimulus: one word pending with instr_ready=0, plus 3 bytes of the next word; pulse rst_n low 1 cycle.
  - Required: instr_valid=0, byte_phase=0, overrun=0. A following 4-byte word appears at instr_addr=0.
